// File: rtl/dff_ram_param_pkg.sv
// Shared types and constants for the parametrised DFF register-file RAM.
package dff_ram_param_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Access controls are active-low.
  localparam logic EN_ON    = 1'b0;
  localparam logic WR_WRITE = 1'b0;

  function automatic int lanes_of(input int width, input int lane_w);
    return width / lane_w;
  endfunction

endpackage

// File: rtl/dff_ram.sv
// File intentionally holds no module; see dff_ram_param.sv.

// File: rtl/dff_ram_clear_fsm.sv
// Clear-sweep sequencer: walks clr_addr 0..DEPTH-1 after reset or clear_req, one word per cycle.
// busy is registered and stays high for exactly DEPTH cycles per sweep; clear_req during a sweep is ignored.
module dff_ram_clear_fsm
  import dff_ram_param_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      busy     <= 1'b1;
      clr_addr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: begin
          if (clear_req) begin
            state    <= ST_CLEAR;
            busy     <= 1'b1;
            clr_addr <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/dff_ram_param.sv
// Single-port DFF RAM with per-lane write mask and registered read (1-cycle latency, rd_valid strobe).
// Accesses are dropped while busy (clear sweep) and in the cycle clear_req is seen; no other stalls.
module dff_ram_param
  import dff_ram_param_pkg::*;
#(
  parameter int WIDTH  = 72,
  parameter int DEPTH  = 4,
  parameter int LANE_W = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int LANES  = lanes_of(WIDTH, LANE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] address,
  input  logic [LANES-1:0]  wmask,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              clear_req,
  output logic [WIDTH-1:0]  data_out,
  output logic              rd_valid,
  output logic              busy
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] clr_addr;
  logic              in_range;
  logic              acc_go;
  logic              wr_go;
  logic              rd_go;

  dff_ram_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_addr  (clr_addr)
  );

  generate
    if ((2 ** ADDR_W) == DEPTH) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = (32'(address) < DEPTH);
    end
  endgenerate

  // A same-cycle clear_req pre-empts the access; the sweep is about to wipe the array anyway.
  assign acc_go = !busy && !clear_req && (en == EN_ON);
  assign wr_go  = acc_go && (wr == WR_WRITE) && in_range;
  assign rd_go  = acc_go && (wr != WR_WRITE);

  // Storage has no reset; the sweep zeroes it before any read can see it.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_addr] <= '0;
    end else if (wr_go) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) begin
          mem[address][i*LANE_W +: LANE_W] <= data_in[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go) begin
        data_out <= in_range ? mem[address] : '0;
      end
    end
  end

endmodule

// File: tb/tb_dff_ram_param.sv
// Directed bench: DEPTH=4 and DEPTH=5 instances driven in lockstep from shared inputs.
module tb_dff_ram_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        wr;
  logic [2:0]  addr;
  logic [8:0]  wmask;
  logic [71:0] data_in;
  logic        clear_req;
  logic [71:0] dout4, dout5;
  logic        vld4, vld5, busy4, busy5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dff_ram_param #(.WIDTH(72), .DEPTH(4), .LANE_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .address(addr[1:0]),
    .wmask(wmask), .data_in(data_in), .clear_req(clear_req),
    .data_out(dout4), .rd_valid(vld4), .busy(busy4)
  );

  dff_ram_param #(.WIDTH(72), .DEPTH(5), .LANE_W(8)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .address(addr),
    .wmask(wmask), .data_in(data_in), .clear_req(clear_req),
    .data_out(dout5), .rd_valid(vld5), .busy(busy5)
  );

  typedef struct {
    string       name;
    logic        en;
    logic        wr;
    logic [2:0]  addr;
    logic [8:0]  wmask;
    logic [71:0] din;
    logic        exp_vld;
    logic [71:0] exp_dout;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic [2:0] a,
                       input logic [8:0] m, input logic [71:0] d);
    en = e; wr = w; addr = a; wmask = m; data_in = d;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 3'd0, 9'h0, 72'h0);
  endtask

  // Counts cycles each instance stays busy, starting from the current sample point.
  task automatic count_busy(input string nm, input int exp4, input int exp5);
    int c4 = 0;
    int c5 = 0;
    int n  = 0;
    while ((busy4 || busy5) && n < 20) begin
      if (busy4) c4++;
      if (busy5) c5++;
      n++;
      step();
    end
    chk({nm, "_busy4"}, 72'(c4), 72'(exp4));
    chk({nm, "_busy5"}, 72'(c5), 72'(exp5));
  endtask

  task automatic rd(input string nm, input logic [2:0] a, input logic [71:0] exp, input logic chk5);
    drive(1'b0, 1'b1, a, 9'h0, 72'h0);
    step();
    chk({nm, "_vld4"}, 72'(vld4), 72'd1);
    chk({nm, "_dout4"}, dout4, exp);
    if (chk5) begin
      chk({nm, "_vld5"}, 72'(vld5), 72'd1);
      chk({nm, "_dout5"}, dout5, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{"rd0_init", 1'b0, 1'b1, 3'd0, 9'h000, 72'h0, 1'b1, 72'h0};
    vecs[1]  = '{"rd1_init", 1'b0, 1'b1, 3'd1, 9'h000, 72'h0, 1'b1, 72'h0};
    vecs[2]  = '{"rd2_init", 1'b0, 1'b1, 3'd2, 9'h000, 72'h0, 1'b1, 72'h0};
    vecs[3]  = '{"rd3_init", 1'b0, 1'b1, 3'd3, 9'h000, 72'h0, 1'b1, 72'h0};
    vecs[4]  = '{"wr0_full", 1'b0, 1'b0, 3'd0, 9'h1FF, 72'h123456789ABCDEF012, 1'b0, 72'h0};
    vecs[5]  = '{"rd0_full", 1'b0, 1'b1, 3'd0, 9'h000, 72'h0, 1'b1, 72'h123456789ABCDEF012};
    vecs[6]  = '{"noacc",    1'b1, 1'b1, 3'd0, 9'h000, 72'h0, 1'b0, 72'h123456789ABCDEF012};
    vecs[7]  = '{"wr1_ones", 1'b0, 1'b0, 3'd1, 9'h1FF, 72'hFFFFFFFFFFFFFFFFFF, 1'b0, 72'h123456789ABCDEF012};
    vecs[8]  = '{"wr1_lane0", 1'b0, 1'b0, 3'd1, 9'h001, 72'h0, 1'b0, 72'h123456789ABCDEF012};
    vecs[9]  = '{"rd1_part", 1'b0, 1'b1, 3'd1, 9'h000, 72'h0, 1'b1, 72'hFFFFFFFFFFFFFFFF00};
    vecs[10] = '{"wr2_nomask", 1'b0, 1'b0, 3'd2, 9'h000, 72'hAAAAAAAAAAAAAAAAAA, 1'b0, 72'hFFFFFFFFFFFFFFFF00};
    vecs[11] = '{"rd2_nomask", 1'b0, 1'b1, 3'd2, 9'h000, 72'h0, 1'b1, 72'h0};
    vecs[12] = '{"wr3_l1l8", 1'b0, 1'b0, 3'd3, 9'h102, 72'hA1A2A3A4A5A6A7A8A9, 1'b0, 72'h0};
    vecs[13] = '{"rd3_l1l8", 1'b0, 1'b1, 3'd3, 9'h000, 72'h0, 1'b1, 72'hA1000000000000A800};
    vecs[14] = '{"rd0_b2b",  1'b0, 1'b1, 3'd0, 9'h000, 72'h0, 1'b1, 72'h123456789ABCDEF012};
    vecs[15] = '{"wr2_full", 1'b0, 1'b0, 3'd2, 9'h1FF, 72'hFEDCBA9876543210AB, 1'b0, 72'h123456789ABCDEF012};
    vecs[16] = '{"rd2_new",  1'b0, 1'b1, 3'd2, 9'h000, 72'h0, 1'b1, 72'hFEDCBA9876543210AB};
    vecs[17] = '{"wr2_en_off", 1'b1, 1'b0, 3'd2, 9'h1FF, 72'h0, 1'b0, 72'hFEDCBA9876543210AB};
    vecs[18] = '{"rd2_kept", 1'b0, 1'b1, 3'd2, 9'h000, 72'h0, 1'b1, 72'hFEDCBA9876543210AB};

    rst_n = 1'b0;
    clear_req = 1'b0;
    idle();
    step();
    step();
    chk("rst_busy", 72'(busy4), 72'd1);
    chk("rst_vld", 72'(vld4), 72'd0);
    chk("rst_dout", dout4, 72'h0);
    rst_n = 1'b1;
    count_busy("post_rst", 4, 5);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].wmask, vecs[i].din);
      step();
      chk({vecs[i].name, "_vld4"}, 72'(vld4), 72'(vecs[i].exp_vld));
      chk({vecs[i].name, "_dout4"}, dout4, vecs[i].exp_dout);
      chk({vecs[i].name, "_vld5"}, 72'(vld5), 72'(vecs[i].exp_vld));
      chk({vecs[i].name, "_dout5"}, dout5, vecs[i].exp_dout);
    end
    idle();
    step();
    chk("vld_one_cycle", 72'(vld4), 72'd0);

    // Clear with a same-cycle write; reads held during the sweep must not fire.
    clear_req = 1'b1;
    drive(1'b0, 1'b0, 3'd2, 9'h1FF, 72'h555555555555555555);
    step();
    clear_req = 1'b0;
    drive(1'b0, 1'b1, 3'd0, 9'h0, 72'h0);
    begin
      int c4 = 0;
      int n = 0;
      int bad_vld = 0;
      while (busy4 && n < 20) begin
        c4++;
        n++;
        if (vld4) bad_vld++;
        clear_req = (c4 == 2);
        step();
      end
      clear_req = 1'b0;
      chk("clr_busy4", 72'(c4), 72'd4);
      chk("clr_no_vld", 72'(bad_vld), 72'd0);
    end
    idle();
    step();
    step();
    for (int a = 0; a < 4; a++) rd($sformatf("clr_rd%0d", a), 3'(a), 72'h0, 1'b1);

    // Reset during the second sweep cycle.
    drive(1'b0, 1'b0, 3'd0, 9'h1FF, 72'h0F0F0F0F0F0F0F0F0F);
    step();
    rd("pre_rst", 3'd0, 72'h0F0F0F0F0F0F0F0F0F, 1'b1);
    idle();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("sweep_c1_busy", 72'(busy4), 72'd1);
    step();
    chk("sweep_c2_busy", 72'(busy4), 72'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_dout4", dout4, 72'h0);
    chk("midrst_dout5", dout5, 72'h0);
    chk("midrst_busy", 72'(busy4), 72'd1);
    step();
    step();
    rst_n = 1'b1;
    count_busy("post_midrst", 4, 5);

    // Out-of-range handling on the DEPTH=5 instance.
    drive(1'b0, 1'b0, 3'd4, 9'h1FF, 72'hDEADBEEFCAFEF00D42);
    step();
    drive(1'b0, 1'b0, 3'd6, 9'h1FF, 72'hFFFFFFFFFFFFFFFFFF);
    step();
    drive(1'b0, 1'b1, 3'd4, 9'h0, 72'h0);
    step();
    chk("d5_rd4_vld", 72'(vld5), 72'd1);
    chk("d5_rd4_dout", dout5, 72'hDEADBEEFCAFEF00D42);
    drive(1'b0, 1'b1, 3'd6, 9'h0, 72'h0);
    step();
    chk("d5_rd6_vld", 72'(vld5), 72'd1);
    chk("d5_rd6_dout", dout5, 72'h0);
    drive(1'b0, 1'b1, 3'd5, 9'h0, 72'h0);
    step();
    chk("d5_rd5_dout", dout5, 72'h0);
    drive(1'b0, 1'b1, 3'd4, 9'h0, 72'h0);
    step();
    chk("d5_rd4_again", dout5, 72'hDEADBEEFCAFEF00D42);
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
